// File: rtl/sync_filter_edge.sv
// Multi-channel asynchronous input synchroniser with selectable clock edge, optional glitch filter
// and registered per-channel rise/fall strobes that are coincident with the out_data change.
module sync_filter_edge #(
  parameter int                 WIDTH     = 1,
  parameter int                 STAGES    = 2,
  parameter int                 NEG_EDGE  = 0,
  parameter int                 FILTER    = 0,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic               out_clk,
  input  logic               out_rst_n,
  input  logic [WIDTH-1:0]   in,
  output logic [WIDTH-1:0]   out_data,
  output logic [WIDTH-1:0]   out_rise,
  output logic [WIDTH-1:0]   out_fall,
  output logic               out_changed
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter_edge: STAGES must be >= 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_filter_edge: WIDTH must be >= 1");
  end

  logic               w_clk;
  logic [WIDTH-1:0]   w_sync;
  logic [WIDTH-1:0]   w_data;
  logic [WIDTH-1:0]   w_data_nxt;
  logic [WIDTH-1:0]   r_rise;
  logic [WIDTH-1:0]   r_fall;
  logic               r_changed;

  // Every flop in the block runs on this one edge, so negedge operation is a pure clock inversion.
  if (NEG_EDGE != 0) begin : g_neg_clk
    assign w_clk = ~out_clk;
  end else begin : g_pos_clk
    assign w_clk = out_clk;
  end

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge w_clk or negedge out_rst_n) begin
    if (!out_rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_sync[k] <= RESET_VAL;
      end
    end else begin
      r_sync[0] <= in;
      for (int k = 1; k < STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_sync = r_sync[STAGES-1];

  if (FILTER == 0) begin : g_bypass
    // The last chain flop is the output; its next state is the previous flop.
    assign w_data     = w_sync;
    assign w_data_nxt = r_sync[STAGES-2];
  end else begin : g_filter
    localparam int CW = $clog2(FILTER + 1);

    logic [WIDTH-1:0][CW-1:0] r_cnt;
    logic [WIDTH-1:0]         r_data;
    logic [WIDTH-1:0]         w_accept;

    always_comb begin
      w_accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
        w_accept[i] = (w_sync[i] != r_data[i]) && (r_cnt[i] == CW'(FILTER - 1));
      end
    end

    assign w_data_nxt = r_data ^ w_accept;
    assign w_data     = r_data;

    // A sync value agreeing with out_data, even for one edge, restarts the persistence count.
    always_ff @(posedge w_clk or negedge out_rst_n) begin
      if (!out_rst_n) begin
        r_data <= RESET_VAL;
        r_cnt  <= '0;
      end else begin
        r_data <= w_data_nxt;
        for (int i = 0; i < WIDTH; i++) begin
          if ((w_sync[i] == r_data[i]) || w_accept[i]) begin
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge w_clk or negedge out_rst_n) begin
    if (!out_rst_n) begin
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_rise    <= w_data_nxt & ~w_data;
      r_fall    <= ~w_data_nxt & w_data;
      r_changed <= |(w_data_nxt ^ w_data);
    end
  end

  assign out_data    = w_data;
  assign out_rise    = r_rise;
  assign out_fall    = r_fall;
  assign out_changed = r_changed;

endmodule

// File: tb/tb_sync_filter_edge.sv
// Randomised scoreboard bench for sync_filter_edge: four configurations share one stimulus loop
// and are checked against a window-rule reference model.
module tb_sync_filter_edge;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] r;
    logic [3:0] f;
    logic       c;
  } exp_t;

  // Configurations: A bypass/posedge, B deep chain/negedge/filter 3, C filter 5, D filter 1.
  localparam int         ST  [4] = '{2, 4, 3, 2};
  localparam int         FL  [4] = '{0, 3, 5, 1};
  localparam logic [3:0] RV  [4] = '{4'b0101, 4'b0010, 4'b0000, 4'b0001};
  localparam logic [3:0] MSK [4] = '{4'hf, 4'h3, 4'h7, 4'h1};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] stim [4];
  logic [3:0] nxt  [4];

  logic [3:0] a_d, a_r, a_f; logic a_c;
  logic [1:0] b_d, b_r, b_f; logic b_c;
  logic [2:0] c_d, c_r, c_f; logic c_c;
  logic [0:0] d_d, d_r, d_f; logic d_c;

  logic [3:0] od [4], orr [4], ofl [4];
  logic       oc [4];

  logic [3:0] xs [4][8192];
  int         n  [4];
  logic [3:0] dcur [4];
  exp_t       q  [4][$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_filter_edge #(.WIDTH(4), .STAGES(2), .NEG_EDGE(0), .FILTER(0), .RESET_VAL(4'b0101)) u_a (
    .out_clk(clk), .out_rst_n(rst_n), .in(stim[0]),
    .out_data(a_d), .out_rise(a_r), .out_fall(a_f), .out_changed(a_c));

  sync_filter_edge #(.WIDTH(2), .STAGES(4), .NEG_EDGE(1), .FILTER(3), .RESET_VAL(2'b10)) u_b (
    .out_clk(clk), .out_rst_n(rst_n), .in(stim[1][1:0]),
    .out_data(b_d), .out_rise(b_r), .out_fall(b_f), .out_changed(b_c));

  sync_filter_edge #(.WIDTH(3), .STAGES(3), .NEG_EDGE(0), .FILTER(5), .RESET_VAL(3'b000)) u_c (
    .out_clk(clk), .out_rst_n(rst_n), .in(stim[2][2:0]),
    .out_data(c_d), .out_rise(c_r), .out_fall(c_f), .out_changed(c_c));

  sync_filter_edge #(.WIDTH(1), .STAGES(2), .NEG_EDGE(0), .FILTER(1), .RESET_VAL(1'b1)) u_d (
    .out_clk(clk), .out_rst_n(rst_n), .in(stim[3][0:0]),
    .out_data(d_d), .out_rise(d_r), .out_fall(d_f), .out_changed(d_c));

  always_comb begin
    od[0] = a_d;          orr[0] = a_r;          ofl[0] = a_f;          oc[0] = a_c;
    od[1] = {2'b00, b_d}; orr[1] = {2'b00, b_r}; ofl[1] = {2'b00, b_f}; oc[1] = b_c;
    od[2] = {1'b0, c_d};  orr[2] = {1'b0, c_r};  ofl[2] = {1'b0, c_f};  oc[2] = c_c;
    od[3] = {3'b000, d_d}; orr[3] = {3'b000, d_r}; ofl[3] = {3'b000, d_f}; oc[3] = d_c;
  end

  // Synchronised value after active edge j: the input sampled STAGES-1 edges earlier.
  function automatic logic [3:0] sync_at(input int k, input int j);
    if (j - ST[k] + 1 >= 1) return xs[k][j - ST[k] + 1];
    return RV[k];
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] dn, input logic [3:0] dold);
    exp_t e;
    e.d = dn;
    e.r = dn & ~dold;
    e.f = ~dn & dold;
    e.c = |(dn ^ dold);
    return e;
  endfunction

  task automatic model_reset(input int k);
    n[k]    = 0;
    dcur[k] = RV[k];
    q[k].push_back(mk_exp(RV[k], RV[k]));
  endtask

  // A bit flips once its synchronised value has differed from out_data on each of the last FILTER edges.
  task automatic step(input int k);
    logic [3:0] dn;
    logic [3:0] s;
    bit         all_diff;
    n[k]++;
    xs[k][n[k]] = stim[k];
    if (FL[k] == 0) begin
      dn = sync_at(k, n[k]);
    end else begin
      dn = dcur[k];
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int j = n[k] - FL[k]; j < n[k]; j++) begin
          s = sync_at(k, j);
          if (s[b] == dcur[k][b]) all_diff = 1'b0;
        end
        if (all_diff && MSK[k][b]) dn[b] = ~dcur[k][b];
      end
    end
    q[k].push_back(mk_exp(dn, dcur[k]));
    dcur[k] = dn;
  endtask

  task automatic tick(input bit rstv);
    @(posedge clk);
    #2;
    rst_n = rstv;
    for (int k = 0; k < 4; k++) begin
      stim[k] = nxt[k] & MSK[k];
      if (!rstv) model_reset(k);
      else       step(k);
    end
  endtask

  task automatic hold(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b1);
  endtask

  task automatic set_all(input bit inv);
    for (int k = 0; k < 4; k++) nxt[k] = inv ? ~RV[k] : RV[k];
  endtask

  task automatic check(input int k);
    exp_t e;
    if (q[k].size() == 0) return;
    e = q[k].pop_front();
    n_chk++;
    if (od[k] !== e.d || orr[k] !== e.r || ofl[k] !== e.f || oc[k] !== e.c) begin
      n_fail++;
      $display("FAIL dut%0d t=%0t data=%b want %b rise=%b want %b fall=%b want %b changed=%b want %b",
               k, $time, od[k], e.d, orr[k], e.r, ofl[k], e.f, oc[k], e.c);
    end
  endtask

  // Posedge configurations are observed just after posedge; the negedge one just after negedge,
  // so a negedge block clocking on posedge would be caught half a cycle early.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check(0);
      check(2);
      check(3);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      check(1);
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      stim[k] = RV[k];
      nxt[k]  = RV[k];
      n[k]    = 0;
      dcur[k] = RV[k];
    end
    #1 rst_n = 1'b0;
    tick(1'b0); tick(1'b0); tick(1'b0);

    // Release with inputs at reset value, then single-cycle all-channel changes and glitch pulses.
    set_all(1'b0); hold(12);
    set_all(1'b1); hold(2);
    set_all(1'b0); hold(14);
    set_all(1'b1); hold(5);
    set_all(1'b0); hold(15);
    set_all(1'b1); hold(10);
    set_all(1'b0); hold(12);

    // Reset in the middle of a filter count, release with all inputs low.
    for (int k = 0; k < 4; k++) nxt[k] = 4'hf;
    hold(ST[2] + 3);
    tick(1'b0); tick(1'b0);
    for (int k = 0; k < 4; k++) nxt[k] = 4'h0;
    tick(1'b1);
    hold(20);

    // Random phases alternating slow toggling and dense glitching, with occasional resets.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 150; i++) begin
        for (int k = 0; k < 4; k++) begin
          for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, (p % 2 == 0) ? 19 : 2) == 0) nxt[k][b] = ~nxt[k][b];
          end
        end
        if ($urandom_range(0, 199) == 0) begin
          tick(1'b0); tick(1'b0);
        end else begin
          tick(1'b1);
        end
      end
    end

    hold(30);
    @(posedge clk);
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_filter_edge.md
Name: sync_filter_edge

Overview:
Parametrised successor to the two-flop single-bit synchronisers. It brings WIDTH independent asynchronous inputs into the out_clk domain through a synchroniser chain of STAGES flops, with a selectable sampling edge. An optional per-channel glitch filter follows the chain. Registered one-cycle rise/fall strobes are produced per channel. Used for front-panel, keyboard/mouse and other slow asynchronous status lines.

Parameters:
WIDTH, 1, number of independent channels (>=1)
STAGES, 2, synchroniser flops per channel (>=2; <2 is an elaboration error)
NEG_EDGE, 0, 0 = all flops on posedge out_clk; 1 = all flops on negedge out_clk
FILTER, 0, consecutive sampling edges a new synchronised value must persist before acceptance; 0 = filter bypassed
RESET_VAL, {WIDTH{1'b0}}, per-bit reset value of sync chain and out_data

Ports:
out_clk  input  1  destination-domain clock
out_rst_n  input  1  asynchronous active-low reset
in  input  WIDTH  asynchronous inputs, no timing relation to out_clk
out_data  output  WIDTH  synchronised, filtered level
out_rise  output  WIDTH  one-cycle strobe per channel on a 0->1 change of out_data
out_fall  output  WIDTH  one-cycle strobe per channel on a 1->0 change of out_data
out_changed  output  1  OR of all out_rise and out_fall bits

Behaviour:
- Clock and reset:
  - Reset is asynchronous on out_rst_n low: every sync flop and out_data = RESET_VAL; out_rise, out_fall, out_changed = 0; filter counters = 0.
  - Deassertion is sampled on the active edge selected by NEG_EDGE.
  - Every flop, including strobes and counters, uses only that active edge.
- Sync chain (per bit):
  - s[0] <= in; s[k] <= s[k-1].
  - sync value = s[STAGES-1].
  - No logic between chain flops; chain flops must carry the synchroniser attribute (ASYNC_REG or equivalent).
- FILTER = 0: out_data = sync value. Latency from a stable in change to out_data = STAGES active edges.
- FILTER >= 1, per channel:
  - Counter cnt, width clog2(FILTER+1).
  - sync value == out_data: cnt <= 0.
  - sync value != out_data and cnt < FILTER-1: cnt <= cnt+1.
  - sync value != out_data and cnt == FILTER-1: out_data <= sync value, cnt <= 0.
  - Net effect: a change is accepted only after it differs from out_data on FILTER consecutive edges. Latency = STAGES+FILTER edges.
  - A glitch that disappears from the sync value before acceptance resets cnt; out_data is unchanged.
- Strobes:
  - out_rise[i] is high for exactly one cycle, in the first cycle out_data[i] shows 1 after 0. out_fall likewise for 1->0.
  - Strobes are registered and derived from the next-state of out_data, so they are coincident with the out_data change. They are never combinational from in.
  - Channels are independent: a simultaneous rise on one channel and fall on another both strobe in the same cycle. out_changed = 1 for that one cycle.
  - out_rise and out_fall of one channel are never both high.
- Reset boundary conditions:
  - in equal to RESET_VAL at reset release produces no strobes.
  - in differing from RESET_VAL at release produces a normal strobe after the normal latency.
  - Reset mid-count clears the count; out_data returns to RESET_VAL without producing a strobe.
- Steady toggling: an input toggling slower than the filter window passes every edge.
  - With FILTER = 0, each accepted transition strobes once.
  - A level held indefinitely produces no further strobes.

Test Plan:
- Reset and bypass:
  - Setup: WIDTH=1, STAGES=2, FILTER=0, NEG_EDGE=0; in=0; release reset; raise in just after a posedge.
  - Required: out_data=1 on the 2nd posedge; out_rise=1 for exactly that cycle; out_fall=0 throughout.
- Deep chain on negedge:
  - Setup: STAGES=4, NEG_EDGE=1; toggle in 0->1->0, each level held 10 cycles.
  - Required: out_data follows 4 negedges later; one rise strobe and one fall strobe; no flop changes on posedge.
- Glitch filter:
  - Setup: FILTER=3; pulse in high for 2 cycles, then for 5 cycles.
  - Required: the first pulse gives no out_data change and no strobe. The second gives out_data=1 at STAGES+3 edges after the rising edge; out_fall after the falling edge with the same latency.
- Multi-channel:
  - Setup: WIDTH=4, RESET_VAL=4'b0101; release reset with in=4'b0101; then in=4'b1010 in one cycle.
  - Required: no strobes at release. After latency, out_rise=4'b1010 and out_fall=4'b0101 in the same cycle; out_changed=1 for one cycle; out_data=4'b1010.
- Reset mid-operation:
  - Setup: FILTER=5; hold in=1 for 3 cycles past sync; assert out_rst_n asynchronously between clock edges.
  - Required: outputs immediately at reset values; after release with in=0, no strobes ever occur.
